// File: rtl/dmem_lsu_pkg.sv
// Shared encodings, state type and lane-mask helper for the data-memory load/store unit.
package dmem_lsu_pkg;

    localparam logic [31:0] DMEM_BASE_DEFAULT   = 32'h0000_8000;
    localparam int          DMEM_ADDR_W_DEFAULT = 14;

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } lsu_state_e;

    // Byte lanes touched by an access of the given size at the given (already aligned) offset.
    function automatic logic [3:0] laneMask(input logic [1:0] size, input logic [1:0] offset);
        logic [3:0] mask;
        mask = 4'b0000;
        case (size)
            SZ_B:    mask = 4'b0001 << offset;
            SZ_H:    mask = offset[1] ? 4'b1100 : 4'b0011;
            SZ_W:    mask = 4'b1111;
            default: mask = 4'b0000;
        endcase
        return mask;
    endfunction

endpackage

// File: rtl/dmem_lsu_load_align.sv
// Selects the addressed lanes of a bank read word and sign- or zero-extends them.
module dmem_lsu_load_align
    import dmem_lsu_pkg::*;
(
    input  logic [31:0] i_rdData,
    input  logic [1:0]  i_offset,
    input  logic [1:0]  i_size,
    input  logic        i_unsigned,
    output logic [31:0] o_data
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        w_byte = 8'h00;
        case (i_offset)
            2'd0: w_byte = i_rdData[7:0];
            2'd1: w_byte = i_rdData[15:8];
            2'd2: w_byte = i_rdData[23:16];
            2'd3: w_byte = i_rdData[31:24];
            default: w_byte = 8'h00;
        endcase
        w_half = i_offset[1] ? i_rdData[31:16] : i_rdData[15:0];

        o_data = 32'h0;
        case (i_size)
            SZ_B:    o_data = {{24{~i_unsigned & w_byte[7]}}, w_byte};
            SZ_H:    o_data = {{16{~i_unsigned & w_half[15]}}, w_half};
            SZ_W:    o_data = i_rdData;
            default: o_data = 32'h0;
        endcase
    end

endmodule

// File: rtl/dmem_lsu.sv
// Load/store initiator for four byte-lane data banks with a one-deep response slot.
// Define LSU_MISALIGN_TRAP_EN to fault misaligned half/word accesses instead of forcing alignment.
module dmem_lsu
    import dmem_lsu_pkg::*;
#(
    parameter logic [31:0] DMEM_BASE   = DMEM_BASE_DEFAULT,
    parameter int          DMEM_ADDR_W = DMEM_ADDR_W_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic [3:0]  mem_valid,
    output logic [3:0]  mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wr_data,
    input  logic [31:0] mem_rd_data
);

    lsu_state_e  r_state;
    logic [1:0]  r_offset;
    logic [1:0]  r_size;
    logic        r_unsigned;
    logic        r_isLoad;
    logic        r_err;

    logic        w_fire;
    logic        w_access;
    logic        w_fault;
    logic        w_sizeBad;
    logic        w_inRange;
    logic        w_misalign;
    logic [1:0]  w_offset;
    logic [32:0] w_base;
    logic [32:0] w_limit;
    logic [32:0] w_addrExt;
    logic [31:0] w_loadData;

    // Window check done in 33 bits so a window ending at 2^32 cannot wrap.
    assign w_base    = {1'b0, DMEM_BASE};
    assign w_limit   = w_base + (33'd1 << DMEM_ADDR_W);
    assign w_addrExt = {1'b0, req_addr};
    assign w_inRange = (w_addrExt >= w_base) && (w_addrExt < w_limit);
    assign w_sizeBad = (req_size == 2'b11);

    // Low address bits are always forced aligned; with trapping, misaligned requests fault anyway.
    always_comb begin
        w_offset = req_addr[1:0];
        if (req_size == SZ_H) begin
            w_offset = {req_addr[1], 1'b0};
        end else if (req_size == SZ_W) begin
            w_offset = 2'b00;
        end
    end

`ifdef LSU_MISALIGN_TRAP_EN
    assign w_misalign = ((req_size == SZ_H) && req_addr[0]) ||
                        ((req_size == SZ_W) && (req_addr[1:0] != 2'b00));
`else
    assign w_misalign = 1'b0;
`endif

    assign w_fault   = w_sizeBad || !w_inRange || w_misalign;
    assign req_ready = (r_state == EMPTY) || rsp_ready;
    assign w_fire    = req_valid && req_ready;
    assign w_access  = w_fire && !w_fault;

    // Banks only move their read address when enabled, so a stalled response stays put.
    assign mem_valid = w_access ? 4'b1111 : 4'b0000;
    assign mem_we    = (w_access && req_we) ? laneMask(req_size, w_offset) : 4'b0000;
    assign mem_addr  = {req_addr[31:2], 2'b00};

    always_comb begin
        mem_wr_data = req_wdata;
        case (req_size)
            SZ_B:    mem_wr_data = {4{req_wdata[7:0]}};
            SZ_H:    mem_wr_data = {2{req_wdata[15:0]}};
            default: mem_wr_data = req_wdata;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= EMPTY;
            r_offset   <= 2'b00;
            r_size     <= SZ_B;
            r_unsigned <= 1'b0;
            r_isLoad   <= 1'b0;
            r_err      <= 1'b0;
        end else if (w_fire) begin
            r_state    <= FULL;
            r_offset   <= w_offset;
            r_size     <= req_size;
            r_unsigned <= req_unsigned;
            r_isLoad   <= !req_we;
            r_err      <= w_fault;
        end else if (rsp_ready) begin
            r_state    <= EMPTY;
            r_isLoad   <= 1'b0;
            r_err      <= 1'b0;
        end
    end

    dmem_lsu_load_align u_align (
        .i_rdData   (mem_rd_data),
        .i_offset   (r_offset),
        .i_size     (r_size),
        .i_unsigned (r_unsigned),
        .o_data     (w_loadData)
    );

    assign rsp_valid = (r_state == FULL);
    assign rsp_err   = r_err;
    assign rsp_rdata = (r_isLoad && !r_err) ? w_loadData : 32'h0;

endmodule

// File: tb/tb_dmem_lsu.sv
// Directed bench for dmem_lsu with a behavioural four-lane bank model.
module tb_dmem_lsu;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic [3:0]  mem_valid;
    logic [3:0]  mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wr_data;
    logic [31:0] mem_rd_data;

    int total = 0;
    int bad   = 0;

    typedef struct {
        string       name;
        logic        we;
        logic [31:0] addr;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] wdata;
        logic [3:0]  expValid;
        logic [3:0]  expWe;
        logic [31:0] expWrData;
        logic        expErr;
        logic [31:0] expRdata;
    } vec_t;

    vec_t vecs[$];

    dmem_lsu dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_addr     (req_addr),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_wdata    (req_wdata),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_rdata    (rsp_rdata),
        .rsp_err      (rsp_err),
        .mem_valid    (mem_valid),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wr_data  (mem_wr_data),
        .mem_rd_data  (mem_rd_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Bank model: registered read address that only moves on an enabled access.
    logic [31:0] bank [0:4095];
    logic [11:0] rdIdx = 12'd0;
    always @(posedge clk) begin
        if (|mem_valid) begin
            rdIdx <= mem_addr[13:2];
            for (int k = 0; k < 4; k++) begin
                if (mem_we[k]) bank[mem_addr[13:2]][8*k +: 8] <= mem_wr_data[8*k +: 8];
            end
        end
    end
    assign mem_rd_data = bank[rdIdx];

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
        end
    endtask

    task automatic setReq(input logic we, input logic [31:0] addr, input logic [1:0] size,
                          input logic uns, input logic [31:0] wdata);
        req_valid    = 1'b1;
        req_we       = we;
        req_addr     = addr;
        req_size     = size;
        req_unsigned = uns;
        req_wdata    = wdata;
    endtask

    function automatic vec_t mk(input string name, input logic we, input logic [31:0] addr,
                                input logic [1:0] size, input logic uns, input logic [31:0] wdata,
                                input logic [3:0] expValid, input logic [3:0] expWe,
                                input logic [31:0] expWrData, input logic expErr,
                                input logic [31:0] expRdata);
        vec_t v;
        v.name = name; v.we = we; v.addr = addr; v.size = size; v.uns = uns; v.wdata = wdata;
        v.expValid = expValid; v.expWe = expWe; v.expWrData = expWrData;
        v.expErr = expErr; v.expRdata = expRdata;
        return v;
    endfunction

    // Drives one request with rsp_ready high, checks bank signals, then the response.
    task automatic applyStimulus(input vec_t v);
        setReq(v.we, v.addr, v.size, v.uns, v.wdata);
        #1;
        checkOutput({v.name, ".reqReady"}, {31'd0, req_ready}, 32'd1);
        checkOutput({v.name, ".memValid"}, {28'd0, mem_valid}, {28'd0, v.expValid});
        checkOutput({v.name, ".memWe"}, {28'd0, mem_we}, {28'd0, v.expWe});
        if (v.expWe != 4'b0000) checkOutput({v.name, ".memWrData"}, mem_wr_data, v.expWrData);
        @(posedge clk);
        #1;
        checkOutput({v.name, ".rspValid"}, {31'd0, rsp_valid}, 32'd1);
        checkOutput({v.name, ".rspErr"}, {31'd0, rsp_err}, {31'd0, v.expErr});
        checkOutput({v.name, ".rspRdata"}, rsp_rdata, v.expRdata);
    endtask

    initial begin
        rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = 32'h0; req_size = 2'b00;
        req_unsigned = 1'b0; req_wdata = 32'h0; rsp_ready = 1'b1;

        vecs.push_back(mk("sw_beef",  1, 32'h8010, 2'b10, 0, 32'hDEADBEEF, 4'hF, 4'hF, 32'hDEADBEEF, 0, 32'h0));
        vecs.push_back(mk("lw_beef",  0, 32'h8010, 2'b10, 0, 32'h0,        4'hF, 4'h0, 32'h0,        0, 32'hDEADBEEF));
        vecs.push_back(mk("sb_80",    1, 32'h8013, 2'b00, 0, 32'h00000080, 4'hF, 4'h8, 32'h80808080, 0, 32'h0));
        vecs.push_back(mk("lb_80",    0, 32'h8013, 2'b00, 0, 32'h0,        4'hF, 4'h0, 32'h0,        0, 32'hFFFFFF80));
        vecs.push_back(mk("lbu_80",   0, 32'h8013, 2'b00, 1, 32'h0,        4'hF, 4'h0, 32'h0,        0, 32'h00000080));
        vecs.push_back(mk("sh_8001",  1, 32'h8012, 2'b01, 0, 32'h00008001, 4'hF, 4'hC, 32'h80018001, 0, 32'h0));
        vecs.push_back(mk("lh_8001",  0, 32'h8012, 2'b01, 0, 32'h0,        4'hF, 4'h0, 32'h0,        0, 32'hFFFF8001));
        vecs.push_back(mk("lhu_8001", 0, 32'h8012, 2'b01, 1, 32'h0,        4'hF, 4'h0, 32'h0,        0, 32'h00008001));
        vecs.push_back(mk("lh_beef",  0, 32'h8010, 2'b01, 0, 32'h0,        4'hF, 4'h0, 32'h0,        0, 32'hFFFFBEEF));
        vecs.push_back(mk("lbu_be",   0, 32'h8011, 2'b00, 1, 32'h0,        4'hF, 4'h0, 32'h0,        0, 32'h000000BE));
        vecs.push_back(mk("lb_ef",    0, 32'h8010, 2'b00, 0, 32'h0,        4'hF, 4'h0, 32'h0,        0, 32'hFFFFFFEF));
        vecs.push_back(mk("lw_uns",   0, 32'h8010, 2'b10, 1, 32'h0,        4'hF, 4'h0, 32'h0,        0, 32'h8001BEEF));
        vecs.push_back(mk("sw_8004",  1, 32'h8004, 2'b10, 0, 32'hA5A55A5A, 4'hF, 4'hF, 32'hA5A55A5A, 0, 32'h0));
        vecs.push_back(mk("sb_lane1", 1, 32'h8005, 2'b00, 0, 32'h0000003C, 4'hF, 4'h2, 32'h3C3C3C3C, 0, 32'h0));
        vecs.push_back(mk("sw_8000",  1, 32'h8000, 2'b10, 0, 32'h12345678, 4'hF, 4'hF, 32'h12345678, 0, 32'h0));
`ifdef LSU_MISALIGN_TRAP_EN
        vecs.push_back(mk("lw_8002",  0, 32'h8002, 2'b10, 0, 32'h0,        4'h0, 4'h0, 32'h0,        1, 32'h0));
        vecs.push_back(mk("lh_8013",  0, 32'h8013, 2'b01, 0, 32'h0,        4'h0, 4'h0, 32'h0,        1, 32'h0));
`else
        vecs.push_back(mk("lw_8002",  0, 32'h8002, 2'b10, 0, 32'h0,        4'hF, 4'h0, 32'h0,        0, 32'h12345678));
        vecs.push_back(mk("lh_8013",  0, 32'h8013, 2'b01, 0, 32'h0,        4'hF, 4'h0, 32'h0,        0, 32'hFFFF8001));
`endif
        vecs.push_back(mk("sw_top",   1, 32'hBFFC, 2'b10, 0, 32'hCAFEF00D, 4'hF, 4'hF, 32'hCAFEF00D, 0, 32'h0));
        vecs.push_back(mk("lw_top",   0, 32'hBFFC, 2'b10, 0, 32'h0,        4'hF, 4'h0, 32'h0,        0, 32'hCAFEF00D));
        vecs.push_back(mk("lw_above", 0, 32'hC000, 2'b10, 0, 32'h0,        4'h0, 4'h0, 32'h0,        1, 32'h0));
        vecs.push_back(mk("lw_below", 0, 32'h7FFC, 2'b10, 0, 32'h0,        4'h0, 4'h0, 32'h0,        1, 32'h0));
        vecs.push_back(mk("lw_low",   0, 32'h0100, 2'b10, 0, 32'h0,        4'h0, 4'h0, 32'h0,        1, 32'h0));
        vecs.push_back(mk("ld_sz11",  0, 32'h8010, 2'b11, 0, 32'h0,        4'h0, 4'h0, 32'h0,        1, 32'h0));
        vecs.push_back(mk("st_sz11",  1, 32'h8010, 2'b11, 0, 32'hFFFFFFFF, 4'h0, 4'h0, 32'h0,        1, 32'h0));
        vecs.push_back(mk("lw_after", 0, 32'h8010, 2'b10, 0, 32'h0,        4'hF, 4'h0, 32'h0,        0, 32'h8001BEEF));

        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset.rspValid", {31'd0, rsp_valid}, 32'd0);
        checkOutput("reset.rspErr", {31'd0, rsp_err}, 32'd0);
        checkOutput("reset.rspRdata", rsp_rdata, 32'h0);
        rst = 1'b0;
        rsp_ready = 1'b0;
        #1;
        checkOutput("reset.reqReady", {31'd0, req_ready}, 32'd1);
        @(posedge clk);
        #1;

        rsp_ready = 1'b1;
        foreach (vecs[i]) applyStimulus(vecs[i]);
        req_valid = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("drain.rspValid", {31'd0, rsp_valid}, 32'd0);
        checkOutput("drain.rspRdata", rsp_rdata, 32'h0);

        // Stalled load: response must hold and the queued request must not touch the banks.
        rsp_ready = 1'b0;
        setReq(0, 32'h8004, 2'b10, 0, 32'h0);
        #1;
        checkOutput("stall.firstValid", {28'd0, mem_valid}, 32'hF);
        @(posedge clk);
        #1;
        setReq(0, 32'h8010, 2'b10, 0, 32'h0);
        for (int c = 0; c < 3; c++) begin
            #1;
            checkOutput($sformatf("stall%0d.reqReady", c), {31'd0, req_ready}, 32'd0);
            checkOutput($sformatf("stall%0d.memValid", c), {28'd0, mem_valid}, 32'h0);
            checkOutput($sformatf("stall%0d.memWe", c), {28'd0, mem_we}, 32'h0);
            checkOutput($sformatf("stall%0d.rspValid", c), {31'd0, rsp_valid}, 32'd1);
            checkOutput($sformatf("stall%0d.rspRdata", c), rsp_rdata, 32'hA5A53C5A);
            @(posedge clk);
            #1;
        end
        rsp_ready = 1'b1;
        #1;
        checkOutput("release.reqReady", {31'd0, req_ready}, 32'd1);
        checkOutput("release.memValid", {28'd0, mem_valid}, 32'hF);
        @(posedge clk);
        #1;
        checkOutput("release.rspValid", {31'd0, rsp_valid}, 32'd1);
        checkOutput("release.rspRdata", rsp_rdata, 32'h8001BEEF);
        req_valid = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("release.drain", {31'd0, rsp_valid}, 32'd0);

        // Faulting response held under stall, then discarded by reset.
        rsp_ready = 1'b0;
        setReq(0, 32'h0100, 2'b10, 0, 32'h0);
        #1;
        checkOutput("faultStall.memValid", {28'd0, mem_valid}, 32'h0);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        checkOutput("faultStall.rspErr0", {31'd0, rsp_err}, 32'd1);
        @(posedge clk);
        #1;
        checkOutput("faultStall.rspErr1", {31'd0, rsp_err}, 32'd1);
        checkOutput("faultStall.rspRdata", rsp_rdata, 32'h0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("midReset.rspValid", {31'd0, rsp_valid}, 32'd0);
        checkOutput("midReset.rspErr", {31'd0, rsp_err}, 32'd0);
        rst = 1'b0;

        // Pending load response discarded by reset.
        setReq(0, 32'h8010, 2'b10, 0, 32'h0);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        checkOutput("loadReset.rspValidBefore", {31'd0, rsp_valid}, 32'd1);
        checkOutput("loadReset.rspRdataBefore", rsp_rdata, 32'h8001BEEF);
        rst = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("loadReset.rspValid", {31'd0, rsp_valid}, 32'd0);
        checkOutput("loadReset.rspRdata", rsp_rdata, 32'h0);
        rst = 1'b0;
        @(posedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
